// File: rtl/dsp_xor_arb_pkg.sv
// Shared sizing helpers and the in-flight tag type for the DSP XOR macro scheduler.
package dsp_xor_arb_pkg;
    localparam int MAX_LATENCY = 2;
    localparam int MAX_REQ     = 8;
    localparam int TAG_ID_W    = $clog2(MAX_REQ);

    function automatic int ID_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/dsp_xor_arbiter_rr.sv
// Round-robin arbiter: the pointer holds the last winner; search starts just above it.
module dsp_rr_arbiter
    import dsp_xor_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic               advance,
    output logic [N-1:0]       grant,
    output logic [ID_W(N)-1:0] grant_id
);
    localparam int IW = ID_W(N);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_sel;

    // Requests above the pointer take precedence; otherwise wrap to the lowest index.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = req[i] && (IW'(i) > r_ptr);
        end
    end

    assign w_sel = (|w_mask) ? w_mask : req;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (advance) begin
            r_ptr <= grant_id;
        end
    end
endmodule

// File: rtl/dsp_xor_arbiter.sv
// Shares one DSP XOR macro among NUM_REQ requesters; a tag pipeline that moves with
// the macro's CE routes each result back to the requester that issued it.
module dsp_xor_arbiter
    import dsp_xor_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 48,
    parameter int LATENCY = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_A,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_B,
    output logic [NUM_REQ-1:0]       RSP_VALID,
    output logic [WIDTH-1:0]         RSP_DATA,
    output logic [WIDTH-1:0]         DSP_A,
    output logic [WIDTH-1:0]         DSP_B,
    output logic                     DSP_CE,
    output logic                     DSP_RST,
    input  logic [WIDTH-1:0]         DSP_RESULT,
    output logic                     BUSY
);
    localparam int IW = ID_W(NUM_REQ);

    logic               r_dsp_rst;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_grant_id;
    logic               w_issue;
    logic               w_inflight;
    logic               w_ce;
    tag_t               w_issue_tag;
    tag_t               w_last_tag;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    // Macro reset: asserted with RST_N, released on the first clock after RST_N rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dsp_rst <= 1'b1;
        end else begin
            r_dsp_rst <= 1'b0;
        end
    end

    assign w_req = REQ_VALID & {NUM_REQ{~r_dsp_rst}};

    dsp_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (CLK),
        .rst_n    (RST_N),
        .req      (w_req),
        .advance  (w_issue),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    assign w_issue           = |w_grant;
    assign w_issue_tag.valid = w_issue;
    assign w_issue_tag.id    = TAG_ID_W'(w_grant_id);

    // Grant is one-hot, so an AND-OR mux suffices and yields zero when idle.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_a = w_a | ({WIDTH{w_grant[i]}} & REQ_A[i*WIDTH +: WIDTH]);
            w_b = w_b | ({WIDTH{w_grant[i]}} & REQ_B[i*WIDTH +: WIDTH]);
        end
    end

    if (LATENCY == 0) begin : g_lat0
        assign w_last_tag = w_issue_tag;
        assign w_inflight = 1'b0;
    end else begin : g_pipe
        tag_t [LATENCY-1:0] r_tag;

        // Tags advance only with DSP_CE so they stay aligned with the macro's data stages.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_tag <= '0;
            end else if (w_ce) begin
                r_tag[0] <= w_issue_tag;
                for (int k = 1; k < LATENCY; k++) begin
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end

        always_comb begin
            w_inflight = 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                w_inflight = w_inflight | r_tag[k].valid;
            end
        end

        assign w_last_tag = r_tag[LATENCY-1];
    end

    assign w_ce = w_issue | w_inflight;

    always_comb begin
        RSP_VALID = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            RSP_VALID[i] = w_last_tag.valid && (w_last_tag.id == TAG_ID_W'(i));
        end
    end

    assign REQ_READY = w_grant;
    assign RSP_DATA  = DSP_RESULT;
    assign DSP_A     = w_a;
    assign DSP_B     = w_b;
    assign DSP_CE    = w_ce;
    assign DSP_RST   = r_dsp_rst;
    assign BUSY      = w_ce;
endmodule

// File: tb/tb_dsp_xor_arbiter.sv
// Directed bench for dsp_xor_arbiter at LATENCY 2, 1 and 0, each driving a small XOR macro model.
module tb_dsp_xor_arbiter;
    localparam int N = 4;
    localparam int W = 48;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // LATENCY = 2 instance
    logic [N-1:0]   valid, ready, rspv;
    logic [N*W-1:0] a, b;
    logic [W-1:0]   rsp_data, dsp_a, dsp_b, dsp_res;
    logic           dsp_ce, dsp_rst, busy;
    logic [W-1:0]   m2_p1, m2_p2;

    // LATENCY = 1 instance
    logic [N-1:0]   l1_valid, l1_ready, l1_rspv;
    logic [N*W-1:0] l1_a, l1_b;
    logic [W-1:0]   l1_data, l1_da, l1_db, l1_res;
    logic           l1_ce, l1_rst, l1_busy;

    // LATENCY = 0 instance
    logic [N-1:0]   l0_valid, l0_ready, l0_rspv;
    logic [N*W-1:0] l0_a, l0_b;
    logic [W-1:0]   l0_data, l0_da, l0_db, l0_res;
    logic           l0_ce, l0_rst, l0_busy;

    logic [W-1:0] exp_x [N] = '{48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FCF1,
                                48'hFFFF_FFFF_FDF2, 48'hFFFF_FFFF_F2F3};
    logic [N-1:0] s_rdy [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [N-1:0] s_rsp [10] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    dsp_xor_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(2)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ_VALID(valid), .REQ_READY(ready),
        .REQ_A(a), .REQ_B(b), .RSP_VALID(rspv), .RSP_DATA(rsp_data),
        .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_CE(dsp_ce), .DSP_RST(dsp_rst),
        .DSP_RESULT(dsp_res), .BUSY(busy)
    );

    dsp_xor_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(1)) dut_l1 (
        .CLK(clk), .RST_N(rst_n), .REQ_VALID(l1_valid), .REQ_READY(l1_ready),
        .REQ_A(l1_a), .REQ_B(l1_b), .RSP_VALID(l1_rspv), .RSP_DATA(l1_data),
        .DSP_A(l1_da), .DSP_B(l1_db), .DSP_CE(l1_ce), .DSP_RST(l1_rst),
        .DSP_RESULT(l1_res), .BUSY(l1_busy)
    );

    dsp_xor_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(0)) dut_l0 (
        .CLK(clk), .RST_N(rst_n), .REQ_VALID(l0_valid), .REQ_READY(l0_ready),
        .REQ_A(l0_a), .REQ_B(l0_b), .RSP_VALID(l0_rspv), .RSP_DATA(l0_data),
        .DSP_A(l0_da), .DSP_B(l0_db), .DSP_CE(l0_ce), .DSP_RST(l0_rst),
        .DSP_RESULT(l0_res), .BUSY(l0_busy)
    );

    // XOR macro models with CE and synchronous active-high reset
    always @(posedge clk) begin
        if (dsp_rst) begin
            m2_p1 <= '0;
            m2_p2 <= '0;
        end else if (dsp_ce) begin
            m2_p1 <= dsp_a ^ dsp_b;
            m2_p2 <= m2_p1;
        end
    end
    assign dsp_res = m2_p2;

    always @(posedge clk) begin
        if (l1_rst) begin
            l1_res <= '0;
        end else if (l1_ce) begin
            l1_res <= l1_da ^ l1_db;
        end
    end

    assign l0_res = l0_da ^ l0_db;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the LATENCY-2 instance: drive valid, then check at the falling edge.
    task automatic cyc(input string tag, input logic [N-1:0] v, input logic [N-1:0] rdy,
                       input logic [N-1:0] rsp, input logic ce);
        tick();
        valid = v;
        @(negedge clk);
        check({tag, ".ready"}, 64'(ready), 64'(rdy));
        check({tag, ".rspv"},  64'(rspv),  64'(rsp));
        check({tag, ".ce"},    64'(dsp_ce), 64'(ce));
        check({tag, ".busy"},  64'(busy),  64'(ce));
        for (int i = 0; i < N; i++) begin
            if (rsp[i]) check({tag, ".data"}, 64'(rsp_data), 64'(exp_x[i]));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        valid    = '0;
        l0_valid = '0;
        l1_valid = '0;
        l0_a = '0; l0_b = '0; l1_a = '0; l1_b = '0;
        a = '0;
        b = '0;
        a[W +: W] = 48'hFFFF_0000_FFFF;
        b[W +: W] = 48'h0F0F_0F0F_0F0F;
        valid = 4'b0010;
        tick(); tick(); tick();
        @(negedge clk);
        check("rst.ready", 64'(ready),   64'h0);
        check("rst.rspv",  64'(rspv),    64'h0);
        check("rst.ce",    64'(dsp_ce),  64'h0);
        check("rst.dsprst",64'(dsp_rst), 64'h1);
        check("rst.busy",  64'(busy),    64'h0);
        check("rst.dspa",  64'(dsp_a),   64'h0);

        // Release: macro reset holds for one more cycle, then requester 1 is granted
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.dsprst", 64'(dsp_rst), 64'h1);
        check("rel.ready",  64'(ready),   64'h0);
        tick();
        @(negedge clk);
        check("t1.dsprst", 64'(dsp_rst), 64'h0);
        check("t1.ready",  64'(ready),   64'h2);
        check("t1.dspa",   64'(dsp_a),   64'hFFFF_0000_FFFF);
        check("t1.dspb",   64'(dsp_b),   64'h0F0F_0F0F_0F0F);
        check("t1.ce",     64'(dsp_ce),  64'h1);
        check("t1.rspv",   64'(rspv),    64'h0);
        tick();
        valid = '0;
        @(negedge clk);
        check("t1+1.rspv", 64'(rspv),   64'h0);
        check("t1+1.ce",   64'(dsp_ce), 64'h1);
        check("t1+1.dspa", 64'(dsp_a),  64'h0);
        tick();
        @(negedge clk);
        check("t1+2.rspv", 64'(rspv),     64'h2);
        check("t1+2.data", 64'(rsp_data), 64'hF0F0_0F0F_F0F0);
        tick();
        @(negedge clk);
        check("t1+3.rspv", 64'(rspv),   64'h0);
        check("t1+3.ce",   64'(dsp_ce), 64'h0);
        check("t1+3.busy", 64'(busy),   64'h0);

        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = 48'hAAAA_AAAA_AAA0 + 48'(i);
            b[i*W +: W] = 48'h5555_5555_5550 + 48'(i * 256);
        end

        // Pointer to 0, then requesters 0 and 2 alternate; 1 never asks
        cyc("p0", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        cyc("p1", 4'b0101, 4'b0100, 4'b0000, 1'b1);
        cyc("p2", 4'b0101, 4'b0001, 4'b0001, 1'b1);
        cyc("p3", 4'b0101, 4'b0100, 4'b0100, 1'b1);
        cyc("p4", 4'b0101, 4'b0001, 4'b0001, 1'b1);
        cyc("p5", 4'b0000, 4'b0000, 4'b0100, 1'b1);
        cyc("p6", 4'b0000, 4'b0000, 4'b0001, 1'b1);
        cyc("p7", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Idle gaps: CE follows in-flight work, issue and retire overlap at g2
        cyc("g0", 4'b1000, 4'b1000, 4'b0000, 1'b1);
        cyc("g1", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc("g2", 4'b0010, 4'b0010, 4'b1000, 1'b1);
        cyc("g3", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc("g4", 4'b0000, 4'b0000, 4'b0010, 1'b1);
        cyc("g5", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset with two operations in flight
        cyc("r0", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        cyc("r1", 4'b0100, 4'b0100, 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        valid = 4'b1111;
        #1;
        check("mid.dsprst", 64'(dsp_rst), 64'h1);
        check("mid.rspv",   64'(rspv),    64'h0);
        check("mid.ready",  64'(ready),   64'h0);
        check("mid.busy",   64'(busy),    64'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            check("hold.rspv",  64'(rspv),  64'h0);
            check("hold.ready", 64'(ready), 64'h0);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel2.dsprst", 64'(dsp_rst), 64'h1);
        check("rel2.ready",  64'(ready),   64'h0);
        check("rel2.rspv",   64'(rspv),    64'h0);

        // All four valid for 8 cycles straight out of reset
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("s%0d", k), (k < 8) ? 4'b1111 : 4'b0000, s_rdy[k], s_rsp[k], 1'b1);
        end
        cyc("s10", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // LATENCY = 1: result one cycle after issue
        tick();
        l1_valid = 4'b0001;
        l1_a[0 +: W] = 48'h1234;
        l1_b[0 +: W] = 48'h1234;
        @(negedge clk);
        check("l1.c0.ready", 64'(l1_ready), 64'h1);
        check("l1.c0.rspv",  64'(l1_rspv),  64'h0);
        tick();
        l1_b[0 +: W] = 48'h0;
        @(negedge clk);
        check("l1.c1.ready", 64'(l1_ready), 64'h1);
        check("l1.c1.rspv",  64'(l1_rspv),  64'h1);
        check("l1.c1.data",  64'(l1_data),  64'h0);
        tick();
        l1_valid = '0;
        @(negedge clk);
        check("l1.c2.rspv", 64'(l1_rspv), 64'h1);
        check("l1.c2.data", 64'(l1_data), 64'h1234);
        check("l1.c2.ce",   64'(l1_ce),   64'h1);
        tick();
        @(negedge clk);
        check("l1.c3.rspv", 64'(l1_rspv), 64'h0);
        check("l1.c3.ce",   64'(l1_ce),   64'h0);

        // LATENCY = 0: result in the issue cycle
        tick();
        l0_valid = 4'b0001;
        l0_a[0 +: W] = 48'h1234;
        l0_b[0 +: W] = 48'h1234;
        @(negedge clk);
        check("l0.c0.ready", 64'(l0_ready), 64'h1);
        check("l0.c0.rspv",  64'(l0_rspv),  64'h1);
        check("l0.c0.data",  64'(l0_data),  64'h0);
        tick();
        l0_b[0 +: W] = 48'h00FF;
        @(negedge clk);
        check("l0.c1.rspv", 64'(l0_rspv), 64'h1);
        check("l0.c1.data", 64'(l0_data), 64'h12CB);
        tick();
        l0_valid = '0;
        @(negedge clk);
        check("l0.c2.rspv", 64'(l0_rspv), 64'h0);
        check("l0.c2.ce",   64'(l0_ce),   64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_xor_arbiter.md
# dsp_xor_arbiter

Round-robin scheduler that shares one DSP XOR macro instance (48-bit logic datapath, LATENCY 0–2) among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle. A LATENCY-deep tag pipeline tracks each operation in flight, so every result is routed back to the requester that issued it. The block sits between client engines and the macro, drives the macro's CE/RST pins, and never reorders or drops results.

## Interface
- NUM_REQ, 4, number of requesters (2–8)
- WIDTH, 48, operand/result width (1–48); must equal the macro's WIDTH
- LATENCY, 2, macro latency (0–2); must equal the macro's LATENCY
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  NUM_REQ  requester i has an operand pair
- REQ_READY  out  NUM_REQ  requester i granted this cycle
- REQ_A  in  NUM_REQ*WIDTH  operand A, slice i = [i*WIDTH +: WIDTH]
- REQ_B  in  NUM_REQ*WIDTH  operand B, same slicing
- RSP_VALID  out  NUM_REQ  one-hot; result for requester i on RSP_DATA
- RSP_DATA  out  WIDTH  result bus shared by all requesters
- DSP_A, DSP_B  out  WIDTH  macro operands
- DSP_CE  out  1  macro clock enable
- DSP_RST  out  1  macro reset, active-high
- DSP_RESULT  in  WIDTH  macro result
- BUSY  out  1  any operation in flight or being issued

## Operation
- Arbitration: round-robin. The pointer holds the last granted index. Grant goes to the first i with REQ_VALID[i], searching from ptr+1 upward with wrap. One grant per cycle. The pointer updates only on a handshake.
- REQ_READY = grant, combinational from REQ_VALID; a transfer occurs when VALID && READY.
- A requester holds VALID, A and B stable until READY. Dropping VALID without READY is legal; that request is withdrawn.
- Issue: DSP_A/DSP_B = the granted requester's slices. When idle they are 0.
- Tag pipeline: LATENCY stages of {valid, id}, with id width clog2(NUM_REQ). Stage 0 is loaded on issue; the pipeline advances whenever DSP_CE = 1.
- RSP_VALID[id] is driven from the last stage, or from the issue itself when LATENCY = 0. RSP_DATA = DSP_RESULT as a pass-through.
- Requesters take results unconditionally; there is no response back-pressure.
- DSP_CE = issue || any tag stage valid. The macro is therefore frozen only when empty, which keeps tags and data in lockstep.
- DSP_RST is asserted asynchronously with RST_N low and deasserted synchronously one CLK after RST_N rises. While DSP_RST = 1, no grant is made.
- Reset values:
  - REQ_READY = 0, RSP_VALID = 0, DSP_CE = 0, DSP_RST = 1, BUSY = 0
  - all tag stages invalid
  - ptr = NUM_REQ-1, so requester 0 wins first
  - DSP_A/DSP_B = 0
- Reset mid-operation: all in-flight tags are discarded and no RSP_VALID fires for them. Requesters must reissue.

## Timing
- Handshake in cycle t → RSP_VALID asserted in cycle t+LATENCY, for exactly one cycle.
- LATENCY = 0: combinational path REQ_A/B → RSP_DATA in the same cycle.
- Throughput: one operation per cycle sustained; back-to-back issues yield back-to-back responses in issue order.
- First grant is possible in the second cycle after RST_N deasserts.
- The grant path (REQ_VALID → REQ_READY) is combinational and must meet timing at NUM_REQ = 8.
- Simultaneous issue and retire in the same cycle are both handled; BUSY stays 1.

## Structure
- Package dsp_xor_arb_pkg:
  - ID_W(NUM_REQ) function (clog2, minimum 1)
  - MAX_LATENCY = 2
  - MAX_REQ = 8
  - tag struct {valid, id}
- Sub-module dsp_rr_arbiter: parameter N; inputs req[N] and advance; outputs grant[N] and grant_id. It holds the round-robin pointer.
- Top level: arbiter, operand mux, tag shift register, reset synchroniser for DSP_RST. The macro is instantiated by the parent and connected through the DSP_* ports.

## Test plan
- Reset release, single request: req 1 with A=48'hFFFF_0000_FFFF, B=48'h0F0F_0F0F_0F0F at LATENCY=2 → READY[1] on the first eligible cycle; two cycles later RSP_VALID=4'b0010 and RSP_DATA=48'hF0F0_0F0F_F0F0.
- All four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses follow in the same order with no gaps.
- Requesters 0 and 2 only, with the pointer at 0 → grant 2 next, then 0; requester 1 is never granted.
- LATENCY=0 and LATENCY=1 builds, A=B=48'h1234 → RSP_DATA=0, with RSP_VALID in the issue cycle and the issue+1 cycle respectively.
- RST_N pulled low with 2 operations in flight → no RSP_VALID fires afterwards; DSP_RST=1 until one cycle after release; the first grant after reset goes to requester 0.
- Idle gaps between issues → DSP_CE=0 whenever the tag pipeline is empty and nothing is issuing; DSP_CE=1 on every cycle that holds an in-flight operation.
